// File: rtl/prbs_chk_pkg.sv
// Shared types and constants for the PRBS-7 lane checker bank.
// Also holds the self-synchronising error-mask helper used by every lane.
package prbs_chk_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lane_state_t;

    localparam int WORD_W     = 16;
    localparam int PRBS_TAP_A = 6;
    localparam int PRBS_TAP_B = 7;

    localparam int ERR_SEEN  = 0;
    localparam int LOCK_LOST = 1;

    // Bit i of the word should equal the XOR of the bits 6 and 7 older than it.
    function automatic logic [WORD_W-1:0] prbs7_err_mask(
        input logic [PRBS_TAP_B-1:0] prev,
        input logic [WORD_W-1:0]     data
    );
        logic [WORD_W+PRBS_TAP_B-1:0] s;
        logic [WORD_W-1:0]            m;
        s = {prev, data};
        for (int i = 0; i < WORD_W; i++) begin
            m[i] = s[i] ^ s[i+PRBS_TAP_A] ^ s[i+PRBS_TAP_B];
        end
        return m;
    endfunction

endpackage

// File: rtl/prbs_lane_checker_bank_lane.sv
// One-lane PRBS-7 checker: lock FSM, errored-word counter and sticky status.
// Outputs update on the edge that samples the word; rx_valid low holds all lane state.
module prbs7_lane_checker
    import prbs_chk_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              prbs_counter_reset,
    output logic              locked,
    output logic [1:0]        prbs_error,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_CNT - 1);

    lane_state_t            state, state_nxt;
    logic [7:0]             good_run, good_run_nxt;
    logic [7:0]             bad_run, bad_run_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   err_seen, err_seen_nxt;
    logic                   lock_lost, lock_lost_nxt;
    logic [PRBS_TAP_B-1:0]  prev;
    logic                   prev_ok;
    logic [WORD_W-1:0]      err_mask;
    logic                   word_bad;
    logic                   word_good;

    assign err_mask  = prbs7_err_mask(prev, rx_data);
    // The all-zero word is the LFSR lock-up state, so it never passes as clean.
    assign word_bad  = rx_valid && ((rx_data == '0) || (prev_ok && (|err_mask)));
    assign word_good = rx_valid && prev_ok && !word_bad;

    always_comb begin
        state_nxt     = state;
        good_run_nxt  = good_run;
        bad_run_nxt   = bad_run;
        cnt_nxt       = cnt;
        err_seen_nxt  = err_seen;
        lock_lost_nxt = lock_lost;
        case (state)
            HUNT: begin
                if (word_good) begin
                    if (good_run == LOCK_LAST) begin
                        state_nxt    = LOCKED;
                        bad_run_nxt  = '0;
                        good_run_nxt = '0;
                    end else begin
                        good_run_nxt = good_run + 8'd1;
                    end
                end else if (word_bad) begin
                    good_run_nxt = '0;
                end
            end
            LOCKED: begin
                if (word_bad) begin
                    if (cnt != '1) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                    err_seen_nxt = 1'b1;
                    if (bad_run == UNLOCK_LAST) begin
                        state_nxt     = HUNT;
                        good_run_nxt  = '0;
                        bad_run_nxt   = '0;
                        lock_lost_nxt = 1'b1;
                    end else begin
                        bad_run_nxt = bad_run + 8'd1;
                    end
                end else if (word_good) begin
                    bad_run_nxt = '0;
                end
            end
        endcase
        // A clear coincident with a bad word wins over the increment.
        if (prbs_counter_reset) begin
            cnt_nxt       = '0;
            err_seen_nxt  = 1'b0;
            lock_lost_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            good_run  <= '0;
            bad_run   <= '0;
            cnt       <= '0;
            err_seen  <= 1'b0;
            lock_lost <= 1'b0;
            prev      <= '0;
            prev_ok   <= 1'b0;
        end else begin
            state     <= state_nxt;
            good_run  <= good_run_nxt;
            bad_run   <= bad_run_nxt;
            cnt       <= cnt_nxt;
            err_seen  <= err_seen_nxt;
            lock_lost <= lock_lost_nxt;
            if (rx_valid) begin
                prev    <= rx_data[PRBS_TAP_B-1:0];
                prev_ok <= 1'b1;
            end
        end
    end

    assign locked                = (state == LOCKED);
    assign prbs_error[ERR_SEEN]  = err_seen;
    assign prbs_error[LOCK_LOST] = lock_lost || (state != LOCKED);
    assign err_count             = cnt;

endmodule

// File: rtl/prbs_lane_checker_bank.sv
// NLINKS-lane PRBS-7 checker bank; prbs_start flags that every lane is locked.
// prbs_start is registered and lags locked by one cycle; no backpressure, rx_valid qualifies words.
module prbs_lane_checker_bank
    import prbs_chk_pkg::*;
#(
    parameter int NLINKS     = 4,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NLINKS-1:0][WORD_W-1:0] rx_data,
    input  logic [NLINKS-1:0]             rx_valid,
    input  logic                          prbs_counter_reset,
    output logic                          prbs_start,
    output logic [NLINKS-1:0][1:0]        prbs_error,
    output logic [NLINKS-1:0]             locked,
    output logic [NLINKS-1:0][CNT_W-1:0]  err_count
);

    for (genvar g = 0; g < NLINKS; g++) begin : g_lane
        prbs7_lane_checker #(
            .LOCK_CNT   (LOCK_CNT),
            .UNLOCK_CNT (UNLOCK_CNT),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk                (clk),
            .rst                (rst),
            .rx_data            (rx_data[g]),
            .rx_valid           (rx_valid[g]),
            .prbs_counter_reset (prbs_counter_reset),
            .locked             (locked[g]),
            .prbs_error         (prbs_error[g]),
            .err_count          (err_count[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prbs_start <= 1'b0;
        end else begin
            prbs_start <= &locked;
        end
    end

endmodule

// File: tb/tb_prbs_lane_checker_bank.sv
// Self-checking bench for prbs_lane_checker_bank: per-cycle scoreboard against a
// generator-based reference model, plus fixed-value vector table and corner sequences.
module tb_prbs_lane_checker_bank;

    localparam int NL = 4;
    localparam int CW = 4;

    localparam int K_NONE = 0;
    localparam int K_F10  = 1;
    localparam int K_F3   = 2;
    localparam int K_ZERO = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NL-1:0][15:0]     rx_data = '0;
    logic [NL-1:0]           rx_valid = '0;
    logic                    prbs_counter_reset = 1'b0;
    logic                    prbs_start;
    logic [NL-1:0][1:0]      prbs_error;
    logic [NL-1:0]           locked;
    logic [NL-1:0][CW-1:0]   err_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    prbs_lane_checker_bank #(
        .NLINKS     (NL),
        .LOCK_CNT   (16),
        .UNLOCK_CNT (4),
        .CNT_W      (CW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .prbs_counter_reset (prbs_counter_reset),
        .prbs_start         (prbs_start),
        .prbs_error         (prbs_error),
        .locked             (locked),
        .err_count          (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0]         lk;
        logic                  st;
        logic [NL-1:0][1:0]    er;
        logic [NL-1:0][CW-1:0] ct;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [6:0]    gen [NL];
    logic [6:0]    m_prev [NL];
    logic [NL-1:0] m_ok, m_lk, m_seen, m_lost;
    int            m_gr [NL];
    int            m_br [NL];
    int            m_ct [NL];
    logic          m_start;

    // Runs the LFSR 16 steps from a 7-bit history; returns {new history, word}.
    function automatic logic [22:0] adv(input logic [6:0] st);
        logic [6:0]  s;
        logic [15:0] w;
        logic        nb;
        s = st;
        w = '0;
        for (int k = 15; k >= 0; k--) begin
            nb   = s[5] ^ s[6];
            w[k] = nb;
            s    = {s[5:0], nb};
        end
        return {s, w};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        exp_t        e;
        exp_t        got;
        logic        all_lk;
        logic        bad, good;
        logic [22:0] pred;
        all_lk = &m_lk;
        for (int l = 0; l < NL; l++) begin
            if (rst) begin
                m_prev[l] = '0; m_ok[l] = 1'b0; m_lk[l] = 1'b0; m_seen[l] = 1'b0;
                m_lost[l] = 1'b0; m_gr[l] = 0; m_br[l] = 0; m_ct[l] = 0;
            end else begin
                bad  = 1'b0;
                good = 1'b0;
                if (rx_valid[l]) begin
                    pred = adv(m_prev[l]);
                    bad  = (rx_data[l] == 16'h0) || (m_ok[l] && (rx_data[l] != pred[15:0]));
                    good = m_ok[l] && !bad;
                    m_prev[l] = rx_data[l][6:0];
                    m_ok[l]   = 1'b1;
                end
                if (!m_lk[l]) begin
                    if (good) begin
                        if (m_gr[l] + 1 == 16) begin
                            m_lk[l] = 1'b1;
                            m_br[l] = 0;
                        end else begin
                            m_gr[l]++;
                        end
                    end else if (bad) begin
                        m_gr[l] = 0;
                    end
                end else if (bad) begin
                    if (m_ct[l] < (1 << CW) - 1) m_ct[l]++;
                    m_seen[l] = 1'b1;
                    m_br[l]++;
                    if (m_br[l] == 4) begin
                        m_lk[l]   = 1'b0;
                        m_gr[l]   = 0;
                        m_br[l]   = 0;
                        m_lost[l] = 1'b1;
                    end
                end else if (good) begin
                    m_br[l] = 0;
                end
                if (prbs_counter_reset) begin
                    m_ct[l] = 0; m_seen[l] = 1'b0; m_lost[l] = 1'b0;
                end
            end
            e.er[l] = {m_lost[l] | ~m_lk[l], m_seen[l]};
            e.ct[l] = m_ct[l][CW-1:0];
        end
        m_start = rst ? 1'b0 : all_lk;
        e.lk = m_lk;
        e.st = m_start;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e   = sb_q.pop_front();
        got = '{lk: locked, st: prbs_start, er: prbs_error, ct: err_count};
        chk("sb_locked", got.lk, e.lk);
        chk("sb_prbs_start", got.st, e.st);
        chk("sb_prbs_error", got.er, e.er);
        chk("sb_err_count", got.ct, e.ct);
    endtask

    // Drives one word per valid lane (optionally corrupting one lane) and advances a cycle.
    task automatic cyc_drive(input logic [NL-1:0] vld, input int lane, input int kind, input logic clr);
        logic [22:0] nx;
        logic [15:0] w;
        rx_valid = vld;
        prbs_counter_reset = clr;
        for (int l = 0; l < NL; l++) begin
            w = 16'h0;
            if (vld[l]) begin
                nx     = adv(gen[l]);
                gen[l] = nx[22:16];
                w      = nx[15:0];
                if (l == lane) begin
                    case (kind)
                        K_F10:   w[10] = ~w[10];
                        K_F3:    w[3]  = ~w[3];
                        K_ZERO:  w     = 16'h0;
                        default: ;
                    endcase
                end
            end
            rx_data[l] = w;
        end
        step();
        prbs_counter_reset = 1'b0;
    endtask

    typedef struct {
        int         lane;
        int         kind;
        int         nbad;
        logic       clr;
        int         nclean;
        logic [3:0] ecnt;
        logic [1:0] eerr;
        logic       elk;
        logic       est;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int n;
        int c;
        logic [NL-1:0] v;

        tbl[0] = '{3, K_NONE, 0, 1'b1, 3, 4'd0, 2'b00, 1'b1, 1'b1};
        tbl[1] = '{2, K_F10,  1, 1'b0, 2, 4'd1, 2'b01, 1'b1, 1'b1};
        tbl[2] = '{2, K_F3,   1, 1'b1, 2, 4'd2, 2'b01, 1'b1, 1'b1};
        tbl[3] = '{0, K_F10,  2, 1'b1, 2, 4'd2, 2'b01, 1'b1, 1'b1};
        tbl[4] = '{1, K_ZERO, 4, 1'b1, 2, 4'd4, 2'b11, 1'b0, 1'b0};

        for (int l = 0; l < NL; l++) gen[l] = 7'h7F;

        // Reset state
        rst = 1'b1;
        repeat (2) cyc_drive('0, -1, K_NONE, 1'b0);
        chk("rst_locked", locked, 4'h0);
        chk("rst_start", prbs_start, 1'b0);
        chk("rst_prbs_error", prbs_error, 8'hAA);
        chk("rst_err_count", err_count, 16'h0);
        rst = 1'b0;

        // Clean stream: 1 priming word + 16 clean words to lock
        n = 0;
        while (locked != 4'hF && n < 64) begin
            cyc_drive(4'hF, -1, K_NONE, 1'b0);
            n++;
        end
        chk("lock_words", n, 17);
        chk("start_lags_lock", prbs_start, 1'b0);
        cyc_drive(4'hF, -1, K_NONE, 1'b1);
        chk("start_after_lock", prbs_start, 1'b1);
        chk("clr_prbs_error", prbs_error, 8'h00);
        chk("clr_err_count", err_count, 16'h0);

        for (int t = 0; t < 5; t++) begin
            if (tbl[t].clr) cyc_drive(4'hF, -1, K_NONE, 1'b1);
            for (int b = 0; b < tbl[t].nbad; b++) cyc_drive(4'hF, tbl[t].lane, tbl[t].kind, 1'b0);
            for (int k = 0; k < tbl[t].nclean; k++) cyc_drive(4'hF, -1, K_NONE, 1'b0);
            chk($sformatf("vec%0d_cnt", t), err_count[tbl[t].lane], tbl[t].ecnt);
            chk($sformatf("vec%0d_err", t), prbs_error[tbl[t].lane], tbl[t].eerr);
            chk($sformatf("vec%0d_lock", t), locked[tbl[t].lane], tbl[t].elk);
            chk($sformatf("vec%0d_start", t), prbs_start, tbl[t].est);
        end

        // Relock lane 1: first word after the zeros fails against a zero history,
        // the vector already fed it plus one good word, so 15 more good words lock.
        n = 0;
        while (!locked[1] && n < 64) begin
            cyc_drive(4'hF, -1, K_NONE, 1'b0);
            n++;
        end
        chk("relock_words", n, 15);
        chk("relock_err_sticky", prbs_error[1], 2'b11);
        chk("hunt_no_count", err_count[1], 4'd4);
        cyc_drive(4'hF, -1, K_NONE, 1'b1);
        chk("relock_clr_err", prbs_error[1], 2'b00);
        chk("relock_start", prbs_start, 1'b1);

        // Mid-stream reset, then valid on every third cycle
        rst = 1'b1;
        cyc_drive(4'hF, -1, K_NONE, 1'b0);
        rst = 1'b0;
        n = 0;
        c = 0;
        while (locked != 4'hF && c < 300) begin
            v = (c % 3 == 0) ? 4'hF : 4'h0;
            cyc_drive(v, -1, K_NONE, 1'b0);
            if (v != 0) n++;
            c++;
        end
        chk("gap_lock_words", n, 17);
        chk("gap_err_count", err_count, 16'h0);
        chk("gap_prbs_error", prbs_error, 8'h00);

        // Clear coincident with a bad word
        cyc_drive(4'hF, 0, K_F10, 1'b1);
        chk("clr_wins_cnt", err_count[0], 4'd0);
        chk("clr_wins_err", prbs_error[0], 2'b00);
        cyc_drive(4'hF, 0, K_F10, 1'b0);
        chk("after_clr_cnt", err_count[0], 4'd1);
        chk("after_clr_err", prbs_error[0], 2'b01);

        // Saturation with lock kept
        for (int i = 0; i < 20; i++) begin
            cyc_drive(4'hF, 3, K_F10, 1'b0);
            cyc_drive(4'hF, -1, K_NONE, 1'b0);
        end
        chk("sat_cnt", err_count[3], 4'hF);
        chk("sat_lock", locked[3], 1'b1);

        rst = 1'b1;
        cyc_drive(4'hF, -1, K_NONE, 1'b0);
        rst = 1'b0;
        chk("rst2_locked", locked, 4'h0);
        chk("rst2_start", prbs_start, 1'b0);
        chk("rst2_prbs_error", prbs_error, 8'hAA);
        chk("rst2_err_count", err_count, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
